sprite_anim_ctrl: RTL
=====================

// Module: sprite_anim_ctrl
// PURPOSE
//  Parametrised sprite-pose controller for player and enemy characters. Turns movement and
//  status flags into a pose code, a run-frame index and a facing bit. A downstream ROM mux
//  uses these to pick sprite pixels. Adds configurable run-cycle length, loop/ping-pong
//  sequencing, a timed death with a done pulse, and a sticky win pose.
// PARAMETERS
//  RUN_FRAMES    3        number of run frames, >=2
//  PINGPONG      1        1: 0,1,2,1,0,1..; 0: 0,1,2,0,1..
//  FRAME_CYCLES  4194304  Clk cycles per run frame, >=2
//  DIE_CYCLES    50000000 Clk cycles in DIE before die_done pulses, >=1
//  X_W           13       width of x position
//  WIN_X         6326     x threshold for the win pose
//  IDX_W         $clog2(RUN_FRAMES), localparam
// PORTS
//  Clk           in   1      system clock
//  Reset         in   1      synchronous, active-high reset
//  left_on       in   1      move-left key held
//  right_on      in   1      move-right key held
//  is_in_air     in   1      character airborne
//  is_dead       in   1      death event (level, sampled each cycle)
//  x_pos         in   X_W    world x of character
//  pose          out  3      pose_t: STAND/RUN/JUMP/DIE/WIN
//  run_idx       out  IDX_W  run frame; 0 unless pose==RUN
//  facing_left   out  1      1 = mirror/left sprite set
//  die_done      out  1      one-cycle pulse when death animation ends
// BEHAVIOUR
//  - Reset: state STAND, facing right, run_idx 0, frame/die counters 0, win latch 0, die_done 0.
//    Reset mid-operation, including in DIE or WIN, returns to this state on the next edge.
//  - Outputs decode from registered state. An input change appears at the outputs 1 cycle later.
//  - Direction: dir_r = right_on & ~left_on; dir_l = left_on & ~right_on.
//    Both keys or no key means no direction.
//  - Per-cycle priority: dead > win > air > direction > idle.
//  - Any non-terminal state + is_dead -> DIE. Frame counter is cleared, die counter starts at 0.
//  - Any non-terminal state, not dead, ~facing_left & x_pos>=WIN_X -> WIN.
//    WIN is sticky: it ignores all inputs except is_dead and Reset. Dead from WIN -> DIE.
//  - STAND: is_in_air -> JUMP with facing kept.
//    dir_r / dir_l -> RUN with idx 0, counter 0, facing set from the direction.
//  - RUN: is_in_air -> JUMP, frame counter frozen, idx cleared.
//    Direction opposite to facing -> RUN, idx 0, counter 0, facing flipped.
//    Same direction, or both keys held -> keep running. No direction -> STAND, facing kept.
//  - Run timing: counter increments each RUN cycle. At FRAME_CYCLES-1 it wraps to 0 and the
//    frame advances, so every frame lasts exactly FRAME_CYCLES cycles.
//  - Advance, loop mode: idx wraps RUN_FRAMES-1 -> 0.
//  - Advance, ping-pong mode: a dir bit flips at idx 0 and idx RUN_FRAMES-1.
//    The dir bit clears on every entry to RUN.
//  - JUMP: stays while is_in_air, facing frozen. On landing -> STAND next cycle.
//    Direction is re-evaluated from STAND.
//  - DIE: die counter runs to DIE_CYCLES-1, then die_done=1 for exactly 1 cycle.
//    The counter then saturates, DIE holds until Reset, and die_done never re-fires.
//  - Counters are sized to hold FRAME_CYCLES-1 and DIE_CYCLES-1. No overflow is possible.
// STRUCTURE
//  - sprite_anim_pkg: pose_t enum (STAND=0, RUN=1, JUMP=2, DIE=3, WIN=4) and a state enum.
//  - One sub-module, anim_frame_timer (params RUN_FRAMES, PINGPONG, FRAME_CYCLES).
//    Inputs clr/en; outputs idx. Holds the cycle counter, idx and ping-pong dir.
//  - The top holds the FSM, facing register, win latch and die counter.
// TESTING (RUN_FRAMES=3, FRAME_CYCLES=4, DIE_CYCLES=8, WIN_X=100, x_pos=0 unless noted)
//  1 Reset, idle 5 cycles -> pose STAND, idx 0, facing_left 0, die_done 0 throughout.
//  2 PINGPONG=1, right_on held 24 cycles -> RUN. idx changes every 4 cycles: 0,1,2,1,0,1.
//    With PINGPONG=0 the sequence is 0,1,2,0,1,2.
//  3 Running right at idx 2, then left_on only -> next cycle facing_left 1, idx 0, counter 0.
//    Both keys held -> idx keeps advancing with facing unchanged.
//  4 Running, then is_in_air for 6 cycles -> JUMP, idx 0. Keys ignored for facing.
//    Air drops -> STAND 1 cycle later, then RUN if a key is held.
//  5 is_dead pulse for 1 cycle while RUN -> DIE 1 cycle later.
//    die_done high exactly once, 8 cycles after DIE entry. DIE persists with all inputs
//    toggling until Reset.
//  6 Facing right, x_pos=100 -> WIN and it stays WIN after x_pos returns to 0.
//    Facing left at x_pos=150 -> no WIN. Reset asserted in WIN -> STAND.

Source files
------------

// File: rtl/sprite_anim_pkg.sv
// Shared types for the sprite pose controller.
//   pose_t  : pose code seen by the sprite ROM mux
//   state_t : controller FSM state
//   state_to_pose : maps an FSM state to its pose code
package sprite_anim_pkg;

  typedef enum logic [2:0] {
    PoseStand = 3'd0,
    PoseRun   = 3'd1,
    PoseJump  = 3'd2,
    PoseDie   = 3'd3,
    PoseWin   = 3'd4
  } pose_t;

  typedef enum logic [2:0] {
    StStand,
    StRun,
    StJump,
    StDie,
    StWin
  } state_t;

  function automatic pose_t state_to_pose(input state_t s);
    pose_t p;
    unique case (s)
      StStand: p = PoseStand;
      StRun:   p = PoseRun;
      StJump:  p = PoseJump;
      StDie:   p = PoseDie;
      StWin:   p = PoseWin;
      default: p = PoseStand;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/anim_frame_timer.sv
// Run-cycle frame sequencer.
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   clr_i : restart the cycle (counter, frame index and ping-pong direction to 0)
//   en_i  : advance the cycle counter by one
//   idx_o : current run frame index
// Each frame lasts exactly FRAME_CYCLES enabled cycles. In loop mode the index wraps
// RUN_FRAMES-1 -> 0; in ping-pong mode it bounces between 0 and RUN_FRAMES-1.
module anim_frame_timer #(
  parameter int unsigned  RUN_FRAMES   = 3,
  parameter int unsigned  PINGPONG     = 1,
  parameter int unsigned  FRAME_CYCLES = 4,
  localparam int unsigned IDX_W        = $clog2(RUN_FRAMES),
  localparam int unsigned CNT_W        = $clog2(FRAME_CYCLES)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [IDX_W-1:0] idx_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [IDX_W-1:0] IdxLast = IDX_W'(RUN_FRAMES - 1);
  localparam logic [IDX_W-1:0] IdxOne  = IDX_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             dir_q, dir_d;  // ping-pong: 0 counting up, 1 counting down

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    dir_d = dir_q;
    if (clr_i) begin
      cnt_d = '0;
      idx_d = '0;
      dir_d = 1'b0;
    end else if (en_i) begin
      if (cnt_q == CntLast) begin
        cnt_d = '0;
        if (PINGPONG != 0) begin
          if (!dir_q) begin
            if (idx_q == IdxLast) begin
              dir_d = 1'b1;
              idx_d = idx_q - IdxOne;
            end else begin
              idx_d = idx_q + IdxOne;
            end
          end else begin
            if (idx_q == '0) begin
              dir_d = 1'b0;
              idx_d = idx_q + IdxOne;
            end else begin
              idx_d = idx_q - IdxOne;
            end
          end
        end else begin
          idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxOne;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      idx_q <= '0;
      dir_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      dir_q <= dir_d;
    end
  end

  assign idx_o = idx_q;

endmodule

// File: rtl/sprite_anim_ctrl.sv
// Sprite pose controller: turns movement/status flags into a pose code, run frame and facing.
//   Clk, Reset  : clock, synchronous active-high reset
//   left_on     : move-left key held
//   right_on    : move-right key held
//   is_in_air   : character airborne
//   is_dead     : death event level
//   x_pos       : world x of the character
//   pose        : pose_t code (STAND/RUN/JUMP/DIE/WIN)
//   run_idx     : run frame, 0 unless pose is RUN
//   facing_left : 1 selects the mirrored sprite set
//   die_done    : single-cycle pulse when the death animation ends
// All outputs decode from registered state, so inputs show up one cycle later.
module sprite_anim_ctrl
  import sprite_anim_pkg::*;
#(
  parameter int unsigned  RUN_FRAMES   = 3,
  parameter int unsigned  PINGPONG     = 1,
  parameter int unsigned  FRAME_CYCLES = 4194304,
  parameter int unsigned  DIE_CYCLES   = 50000000,
  parameter int unsigned  X_W          = 13,
  parameter int unsigned  WIN_X        = 6326,
  localparam int unsigned IDX_W        = $clog2(RUN_FRAMES)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             left_on,
  input  logic             right_on,
  input  logic             is_in_air,
  input  logic             is_dead,
  input  logic [X_W-1:0]   x_pos,
  output logic [2:0]       pose,
  output logic [IDX_W-1:0] run_idx,
  output logic             facing_left,
  output logic             die_done
);

  localparam int unsigned      DieW    = (DIE_CYCLES > 1) ? $clog2(DIE_CYCLES) : 1;
  localparam logic [DieW-1:0]  DieLast = DieW'(DIE_CYCLES - 1);
  localparam logic [X_W-1:0]   WinX    = X_W'(WIN_X);

  state_t            state_q, state_d;
  logic              facing_q, facing_d;
  logic [DieW-1:0]   die_cnt_q, die_cnt_d;
  logic              die_fired_q, die_fired_d;
  logic              die_done_q, die_done_d;

  logic              tmr_clr, tmr_en;
  logic [IDX_W-1:0]  tmr_idx;

  logic dir_r, dir_l, both_keys, win_hit;

  assign dir_r     = right_on & ~left_on;
  assign dir_l     = left_on & ~right_on;
  assign both_keys = right_on & left_on;
  assign win_hit   = ~facing_q & (x_pos >= WinX);

  always_comb begin
    state_d     = state_q;
    facing_d    = facing_q;
    die_cnt_d   = die_cnt_q;
    die_fired_d = die_fired_q;
    die_done_d  = 1'b0;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;

    unique case (state_q)
      StStand, StRun, StJump: begin
        if (is_dead) begin
          state_d = StDie;
        end else if (win_hit) begin
          state_d = StWin;
        end else begin
          unique case (state_q)
            StStand: begin
              if (is_in_air) begin
                state_d = StJump;
              end else if (dir_r || dir_l) begin
                state_d  = StRun;
                facing_d = dir_l;
                tmr_clr  = 1'b1;
              end
            end
            StRun: begin
              if (is_in_air) begin
                state_d = StJump;  // timer frozen, idx masked by pose
              end else if ((dir_r && facing_q) || (dir_l && !facing_q)) begin
                facing_d = ~facing_q;
                tmr_clr  = 1'b1;
              end else if (dir_r || dir_l || both_keys) begin
                tmr_en = 1'b1;
              end else begin
                state_d = StStand;
              end
            end
            default: begin  // StJump
              if (!is_in_air) state_d = StStand;
            end
          endcase
        end
      end
      StWin: begin
        if (is_dead) state_d = StDie;
      end
      default: ;  // StDie holds until Reset
    endcase

    if (state_d == StDie) tmr_clr = 1'b1;

    // Death timer: restart on entry, saturate at the last count, pulse once.
    if (state_q != StDie && state_d == StDie) begin
      die_cnt_d   = '0;
      die_fired_d = 1'b0;
    end else if (state_q == StDie) begin
      if (die_cnt_q == DieLast) begin
        die_done_d  = ~die_fired_q;
        die_fired_d = 1'b1;
      end else begin
        die_cnt_d = die_cnt_q + DieW'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StStand;
      facing_q    <= 1'b0;
      die_cnt_q   <= '0;
      die_fired_q <= 1'b0;
      die_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      facing_q    <= facing_d;
      die_cnt_q   <= die_cnt_d;
      die_fired_q <= die_fired_d;
      die_done_q  <= die_done_d;
    end
  end

  anim_frame_timer #(
    .RUN_FRAMES  (RUN_FRAMES),
    .PINGPONG    (PINGPONG),
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_timer (
    .clk_i(Clk),
    .rst_i(Reset),
    .clr_i(tmr_clr),
    .en_i (tmr_en),
    .idx_o(tmr_idx)
  );

  assign pose        = state_to_pose(state_q);
  assign run_idx     = (state_q == StRun) ? tmr_idx : '0;
  assign facing_left = facing_q;
  assign die_done    = die_done_q;

endmodule
